// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I type definitions
// Purpose: funct3 encodings for loads/stores and the data-memory port FSM states.
// Ports: none (package).
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane alignment, masks and load extension
// Purpose: purely combinational helper for dmem_port.
// Ports:
//   is_store      : 1 = store encoding of funct3, 0 = load encoding
//   funct3        : access size/sign
//   offset        : address bits [1:0]
//   wdata         : rs2 value to be stored
//   rdata         : word returned by the cache
//   mbe           : cache byte enables (all lanes for loads)
//   mask          : bytes touched by the access (RVFI rmask/wmask shape)
//   wdata_aligned : store data shifted into its byte lanes
//   load_data     : extracted and extended load result
//   illegal       : misaligned access or undefined funct3
module dmem_align
  import rv32i_types::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mbe,
  output logic [3:0]  mask,
  output logic [31:0] wdata_aligned,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic [3:0]  shape;
  logic [31:0] rword;

  always_comb begin
    shape   = 4'b0000;
    illegal = 1'b0;
    if (is_store) begin
      case (funct3)
        sb:      shape = 4'b0001;
        sh:      begin shape = 4'b0011; illegal = offset[0]; end
        sw:      begin shape = 4'b1111; illegal = (offset != 2'b00); end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        lb, lbu: shape = 4'b0001;
        lh, lhu: begin shape = 4'b0011; illegal = offset[0]; end
        lw:      begin shape = 4'b1111; illegal = (offset != 2'b00); end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign mask          = shape << offset;
  // Loads always fetch the whole word; lane selection happens on the way back.
  assign mbe           = is_store ? mask : 4'b1111;
  assign wdata_aligned = wdata << {offset, 3'b000};
  assign rword         = rdata >> {offset, 3'b000};

  always_comb begin
    load_data = 32'd0;
    case (funct3)
      lb:      load_data = {{24{rword[7]}}, rword[7:0]};
      lbu:     load_data = {24'd0, rword[7:0]};
      lh:      load_data = {{16{rword[15]}}, rword[15:0]};
      lhu:     load_data = {16'd0, rword[15:0]};
      lw:      load_data = rword;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - MEM-stage data-memory access unit
// Purpose: issues one cache access per MEM-stage load/store, stalls the
// pipeline until the cache responds, and returns masks and extended data.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_read/req_write  : memory control bits of the MEM-stage instruction
//   req_funct3          : load/store size encoding
//   req_addr, req_wdata : effective address and rs2 value
//   stall, trap, done   : pipeline control (trap/stall combinational)
//   load_data, rmask, wmask : completed-access results, valid while done=1
//   dmem_*              : registered cache request, dmem_rdata/dmem_resp back
module dmem_port
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            trap,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic [3:0]      rmask,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] dmem_address,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [3:0]      dmem_mbe,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp
);

  dmem_state_t state, state_next;

  // Attributes of the in-flight access, captured at issue so the response
  // is decoded against the instruction that launched it.
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;

  logic        al_store;
  logic [2:0]  al_funct3;
  logic [1:0]  al_offset;
  logic [3:0]  al_mbe;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_illegal;

  logic access;
  logic bad;
  logic issue;

  // In IDLE the helper decodes the incoming request; otherwise it decodes
  // the latched access so the response path does not depend on live inputs.
  assign al_store  = (state == IDLE) ? req_write      : lat_store;
  assign al_funct3 = (state == IDLE) ? req_funct3     : lat_funct3;
  assign al_offset = (state == IDLE) ? req_addr[1:0]  : lat_offset;

  dmem_align u_align (
    .is_store      (al_store),
    .funct3        (al_funct3),
    .offset        (al_offset),
    .wdata         (req_wdata),
    .rdata         (dmem_rdata),
    .mbe           (al_mbe),
    .mask          (al_mask),
    .wdata_aligned (al_wdata),
    .load_data     (al_load),
    .illegal       (al_illegal)
  );

  assign access = req_read | req_write;
  assign bad    = al_illegal | (req_read & req_write);
  assign issue  = (state == IDLE) && access && !bad;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    trap       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (access && bad) begin
          trap = 1'b1;
        end else if (issue) begin
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_resp) state_next = DONE;
      end
      DONE: begin
        // The request inputs still show the completed instruction here;
        // returning to IDLE without looking at them prevents a reissue.
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_address <= '0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_mbe     <= 4'b0000;
      dmem_wdata   <= '0;
      load_data    <= '0;
      rmask        <= 4'b0000;
      wmask        <= 4'b0000;
      lat_store    <= 1'b0;
      lat_funct3   <= 3'b000;
      lat_offset   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_address <= {req_addr[XLEN-1:2], 2'b00};
            dmem_read    <= req_read;
            dmem_write   <= req_write;
            dmem_mbe     <= al_mbe;
            dmem_wdata   <= al_wdata;
            lat_store    <= req_write;
            lat_funct3   <= req_funct3;
            lat_offset   <= req_addr[1:0];
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            load_data  <= lat_store ? 32'd0 : al_load;
            rmask      <= lat_store ? 4'b0000 : al_mask;
            wmask      <= lat_store ? al_mask : 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - scoreboard bench for dmem_port
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall, trap, done;
  logic [31:0] load_data;
  logic [3:0]  rmask, wmask;
  logic [31:0] dmem_address;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_resp = 1'b0;

  dmem_port dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .trap         (trap),
    .load_data    (load_data),
    .done         (done),
    .rmask        (rmask),
    .wmask        (wmask),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_mbe     (dmem_mbe),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_trap;
    logic [31:0] ld;
    logic [3:0]  rm;
    logic [3:0]  wm;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops one expected event per done/trap pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_wr_exclusive", 32'(dmem_read & dmem_write), 32'd0);
      if (done || trap) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(done) | (32'(trap) << 1), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_kind", 32'(trap), 32'(e.is_trap));
          if (!e.is_trap) begin
            check("load_data", load_data, e.ld);
            check("rmask", 32'(rmask), 32'(e.rm));
            check("wmask", 32'(wmask), 32'(e.wm));
          end
        end
      end
    end
  end

  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdat, input int k,
                            input logic [3:0] exp_mbe, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_ld, input logic [3:0] exp_rm,
                            input logic [3:0] exp_wm);
    int stalls;
    exp_t e;
    stalls = 0;
    e.is_trap = 1'b0; e.ld = exp_ld; e.rm = exp_rm; e.wm = exp_wm;
    exp_q.push_back(e);
    req_read = rd; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int c = 0; c <= k; c++) begin
      dmem_resp  = (c == k);
      dmem_rdata = (c == k) ? rdat : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall) stalls++;
      if (c == 1) begin
        check({name, "_dmem_read"}, 32'(dmem_read), 32'(rd));
        check({name, "_dmem_write"}, 32'(dmem_write), 32'(wr));
        check({name, "_dmem_address"}, dmem_address, {addr[31:2], 2'b00});
        check({name, "_dmem_mbe"}, 32'(dmem_mbe), 32'(exp_mbe));
        if (wr) check({name, "_dmem_wdata"}, dmem_wdata, exp_wdata);
      end
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
    @(negedge clk);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_done_stall"}, 32'(stall), 32'd0);
    check({name, "_no_reissue"}, 32'(dmem_read | dmem_write), 32'd0);
    check({name, "_stall_cycles"}, 32'(stalls), 32'(k + 1));
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic try_trap(input string name, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
    exp_t e;
    e.is_trap = 1'b1; e.ld = 32'd0; e.rm = 4'd0; e.wm = 4'd0;
    exp_q.push_back(e);
    req_read = rd; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check({name, "_trap"}, 32'(trap), 32'd1);
    check({name, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    check({name, "_no_access"}, 32'(dmem_read | dmem_write), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dmem_read", 32'(dmem_read), 32'd0);
    check("rst_dmem_write", 32'(dmem_write), 32'd0);
    check("rst_dmem_mbe", 32'(dmem_mbe), 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_dmem_address", dmem_address, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_masks", {24'd0, rmask, wmask}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //          name    rd    wr    f3      addr          wdata          rdata         k  mbe      wdata_al       ld             rm       wm
    run_access("sw",   1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        3, 4'b1111, 32'hDEAD_BEEF, 32'h0,         4'b0000, 4'b1111);
    run_access("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1, 4'b1000, 32'hA500_0000, 32'h0,         4'b0000, 4'b1000);
    run_access("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'h0,         32'h12F0_3456, 2, 4'b1111, 32'h0,         32'hFFFF_FFF0, 4'b0100, 4'b0000);
    run_access("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'h0,         32'h12F0_3456, 1, 4'b1111, 32'h0,         32'h0000_00F0, 4'b0100, 4'b0000);
    run_access("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         32'h12F0_3456, 1, 4'b1111, 32'h0,         32'h0000_12F0, 4'b1100, 4'b0000);
    run_access("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0,         32'h12F0_3456, 1, 4'b1111, 32'h0,         32'h0000_3456, 4'b0011, 4'b0000);
    run_access("lh_n", 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h8001_0000, 1, 4'b1111, 32'h0,         32'hFFFF_8001, 4'b1100, 4'b0000);
    run_access("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_BEEF, 32'h0,        2, 4'b1100, 32'hBEEF_0000, 32'h0,         4'b0000, 4'b1100);

    try_trap("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0105);
    try_trap("sh_mis",  1'b0, 1'b1, 3'b001, 32'h0000_0101);
    try_trap("ld_f3",   1'b1, 1'b0, 3'b011, 32'h0000_0100);
    try_trap("st_f3",   1'b0, 1'b1, 3'b100, 32'h0000_0100);
    try_trap("rd_wr",   1'b1, 1'b1, 3'b010, 32'h0000_0100);

    // Back-to-back: second request presented the cycle after DONE.
    run_access("b2b_lw", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h1122_3344, 1, 4'b1111, 32'h0,         32'h1122_3344, 4'b1111, 4'b0000);
    run_access("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'h5566_7788, 32'h0,        1, 4'b1111, 32'h5566_7788, 32'h0,         4'b0000, 4'b1111);

    // Reset while BUSY on a load, then a stale response.
    req_read = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_dmem_read", 32'(dmem_read), 32'd1);
    check("busy_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_read = 1'b0;
    @(negedge clk);
    check("rst_busy_dmem_read", 32'(dmem_read), 32'd0);
    check("rst_busy_stall", 32'(stall), 32'd0);
    check("rst_busy_address", dmem_address, 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    check("stale_resp_done", 32'(done), 32'd0);
    check("stale_resp_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stale_resp_done2", 32'(done), 32'd0);
    check("stale_resp_load_data2", load_data, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Data-memory access unit in the MEM stage of the pipelined RV32I core.
- Consumes the memory fields of the decoded control word: mem_read, mem_write, funct3, the ALU-computed address and rs2 data.
- Drives the data-cache request/response handshake, generates byte masks and aligned write data, and returns extended load data.
- Holds the pipeline stalled until the cache responds; flags misaligned or illegal accesses as traps without touching memory.

Parameters:
XLEN, 32, data/address width; only 32 is supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_read  in  1  ctrl.mem_read of the MEM-stage instruction
req_write  in  1  ctrl.mem_write of the MEM-stage instruction
req_funct3  in  3  ctrl.funct3 (load_funct3_t / store_funct3_t encoding)
req_addr  in  32  effective byte address (ALU output)
req_wdata  in  32  rs2 value for stores
stall  out  1  hold all pipeline registers upstream of and including MEM
trap  out  1  misaligned or illegal access, one cycle, combinational
load_data  out  32  sign/zero-extended load result; valid while done=1
done  out  1  access completed this cycle; pipeline advances at the clock edge
rmask  out  4  byte read mask of the completed load (RVFI)
wmask  out  4  byte write mask of the completed store (RVFI)
dmem_address  out  32  word-aligned address, {req_addr[31:2],2'b00}
dmem_read  out  1  cache read request, registered
dmem_write  out  1  cache write request, registered
dmem_mbe  out  4  byte enables, registered
dmem_wdata  out  32  shifted store data, registered
dmem_rdata  in  32  cache read word
dmem_resp  in  1  one-cycle cache response

Behaviour:
- State machine: IDLE, BUSY, DONE. Reset puts the FSM in IDLE.
- Reset values: dmem_read=0, dmem_write=0, dmem_mbe=0, dmem_wdata=0, dmem_address=0, load_data=0, done=0, rmask=0, wmask=0, trap=0, stall=0.
- IDLE:
  - No request (req_read=0, req_write=0): stall=0, stay in IDLE.
  - Legal request: stall=1 combinationally; latch address, mbe and wdata; set dmem_read or dmem_write; go to BUSY.
  - Illegal request: trap=1 and stall=0, no cache access, stay in IDLE. Illegal means any of:
    - lw/sw with addr[1:0]!=0
    - lh/lhu/sh with addr[0]!=0
    - undefined funct3
    - req_read and req_write both 1
- BUSY:
  - stall=1; dmem_* held stable.
  - On dmem_resp: drop dmem_read/dmem_write at the next edge, latch the extracted load_data and the masks, go to DONE.
  - No timeout: BUSY waits indefinitely for dmem_resp.
- DONE:
  - stall=0 and done=1 for exactly one cycle, then IDLE.
  - The request inputs still hold the completed instruction during DONE and must not reissue.
- Latency: request seen in cycle 0 → dmem_read/dmem_write high from cycle 1 → dmem_resp in cycle k≥1 → done in cycle k+1. Minimum is 2 stall cycles.
- Masks (byte offset o=addr[1:0]):
  - sw: 4'b1111
  - sh: 4'b0011<<o
  - sb: 4'b0001<<o
  - Loads use the same shapes for rmask; dmem_mbe for loads is 4'b1111.
- Store data: dmem_wdata = req_wdata << (8*o).
- Load data: w = dmem_rdata >> (8*o), then:
  - lb: sign-extend w[7:0]
  - lbu: zero-extend w[7:0]
  - lh: sign-extend w[15:0]
  - lhu: zero-extend w[15:0]
  - lw: w
- Stores: load_data=0 and rmask=0. Loads: wmask=0.
- dmem_resp in IDLE or DONE is ignored.
- rst in BUSY or DONE: next state IDLE, all outputs take their reset values at that edge; a later stale dmem_resp is ignored.

Decomposition:
- Shared package rv32i_types gains dmem_state_t {IDLE, BUSY, DONE}.
- Reuse load_funct3_t and store_funct3_t from rv32i_types.
- One combinational sub-module, dmem_align, produces mbe, rmask/wmask, shifted wdata, extended load data and the misaligned flag from funct3, addr[1:0], rs2 and rdata.
- The FSM and registers stay in dmem_port.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, resp 3 cycles after issue → dmem_write=1, dmem_mbe=1111, dmem_wdata=0xDEADBEEF, dmem_address=0x100; stall high 4 cycles; done then wmask=1111.
- sb addr=0x103, wdata=0x000000A5 → dmem_mbe=1000, dmem_wdata=0xA5000000; after resp, wmask=1000, rmask=0.
- lb addr=0x202, rdata=0x12F0_3456 → load_data=0xFFFFFFF0; lbu same → 0x000000F0; lhu addr=0x202 → 0x000012F0; lh addr=0x200 → 0x00003456.
- lw addr=0x105 → trap=1 same cycle, stall=0, dmem_read never asserted; same for sh addr=0x101.
- Back-to-back lw then sw, each with a 1-cycle resp → no reissue during DONE; second request issued the cycle after DONE; dmem_read and dmem_write never high together.
- rst asserted while BUSY on a load → dmem_read=0 and state IDLE after that edge; dmem_resp pulsed next cycle → done stays 0, load_data stays 0.
